uart_packet_parser: RTL

Framing stage between the byte-level UART receiver and the rest of the design. It accepts raw received bytes over a valid/ready handshake and hunts for a sync byte. It buffers a length-prefixed payload, checks an additive checksum, and releases only verified payloads downstream as a valid/ready byte stream with an end-of-packet marker. Corrupt or malformed frames are dropped and counted.

---
 rtl/uart_packet_parser.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/uart_packet_parser.sv
// uart_packet_parser
// Framing stage behind the byte-level UART receiver. It hunts for SYNC and
// then collects LEN plus LEN payload bytes into a local buffer. It checks the
// additive checksum (LEN + payload + CSUM == 0 mod 256). Only verified
// payloads are replayed downstream; rejected frames are counted.
//
// Ports
//   CLKIN        in   system clock, rising edge
//   RESETN       in   asynchronous active-low reset
//   in_data      in   [7:0] byte from the UART receiver
//   in_valid     in   in_data holds a byte
//   in_ready     out  parser accepts a byte this cycle (state-decoded)
//   out_data     out  [7:0] verified payload byte
//   out_valid    out  out_data valid
//   out_ready    in   downstream accepts out_data
//   out_last     out  out_data is the final byte of the packet
//   pkt_ok       out  one-cycle pulse, frame verified
//   pkt_err      out  one-cycle pulse, frame rejected
//   err_count    out  [7:0] rejected-frame count, saturates at 255
//   dbg_state_o  out  [2:0] current FSM state, for observation only
//
// Handshake: a byte moves on a rising CLKIN edge when valid && ready is true
// on that side. The sender holds data/valid stable until it sees ready. The
// receiver never derives ready combinationally from valid.
module uart_packet_parser #(
  parameter logic [7:0] SYNC    = 8'hAA,
  parameter int         MAX_LEN = 16
) (
  input  logic       CLKIN,
  input  logic       RESETN,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [7:0] err_count,
  output logic [2:0] dbg_state_o
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CSUM    = 3'd3,
    S_DRAIN   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      sum_q, sum_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   rd_q, rd_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            wr_en;
  logic            in_acc;
  logic            rd_last;
  logic [7:0]      csum_total;
  logic [7:0]      buf_q [MAX_LEN];

  // Upstream only ever sees backpressure while a packet is being replayed.
  assign in_ready    = (state_q != S_DRAIN);
  assign in_acc      = in_valid && in_ready;
  assign rd_last     = (8'(rd_q) + 8'd1 == len_q);
  assign csum_total  = sum_q + in_data;

  assign out_valid   = (state_q == S_DRAIN);
  assign out_data    = out_valid ? buf_q[rd_q[AW-1:0]] : 8'h00;
  assign out_last    = out_valid && rd_last;
  assign pkt_ok      = ok_q;
  assign pkt_err     = err_q;
  assign err_count   = err_cnt_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    rd_d    = rd_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      S_HUNT: begin
        if (in_acc && (in_data == SYNC)) state_d = S_LEN;
      end
      S_LEN: begin
        if (in_acc) begin
          if ((in_data == 8'd0) || (int'(in_data) > MAX_LEN)) begin
            err_d   = 1'b1;
            state_d = S_HUNT;
          end else begin
            len_d   = in_data;
            sum_d   = in_data;
            idx_d   = '0;
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (in_acc) begin
          wr_en = 1'b1;
          sum_d = sum_q + in_data;
          idx_d = idx_q + 1'b1;
          if (8'(idx_q) + 8'd1 == len_q) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (in_acc) begin
          if (csum_total == 8'd0) begin
            ok_d    = 1'b1;
            rd_d    = '0;
            state_d = S_DRAIN;
          end else begin
            err_d   = 1'b1;
            state_d = S_HUNT;
          end
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (rd_last) begin
            rd_d    = '0;
            state_d = S_HUNT;
          end else begin
            rd_d = rd_q + 1'b1;
          end
        end
      end
      default: state_d = S_HUNT;
    endcase
    err_cnt_d = (err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= S_HUNT;
      len_q     <= 8'd0;
      sum_q     <= 8'd0;
      idx_q     <= '0;
      rd_q      <= '0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      rd_q      <= rd_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Payload storage needs no reset: it is only read after a full frame has
  // been written into it.
  always_ff @(posedge CLKIN) begin
    if (wr_en) buf_q[idx_q[AW-1:0]] <= in_data;
  end

endmodule
